// File: rtl/seq_mult32.sv
// Sequential unsigned 32x32 shift-and-add multiplier.
// A single rca32 ripple adder performs one partial-product step per clock.

module rca32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] s,
    output logic        c
);
    logic w_carry [0:32];

    assign w_carry[0] = c0;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign c = w_carry[32];
endmodule

module seq_mult32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] p
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic        w_accept;
    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_carry;

    assign w_addend = r_lo[0] ? r_mcand : '0;

    rca32 u_rca32 (
        .a  (r_hi),
        .b  (w_addend),
        .c0 (1'b0),
        .s  (w_sum),
        .c  (w_carry)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 6'd31) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start during the done cycle is accepted directly.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            // Shift the 65-bit {carry, sum, lo} right by one.
            {r_hi, r_lo} <= {w_carry, w_sum, r_lo[31:1]};
            r_cnt        <= r_cnt + 6'd1;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign p    = {r_hi, r_lo};
endmodule

// File: tb/tb_seq_mult32.sv
// Self-checking bench for seq_mult32: vector table, random operands against
// a plain-multiplication model, and hand-written multi-cycle corner cases.

module tb_seq_mult32;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] p;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mult32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [63:0] vp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // Returns at the falling edge just after the accepting edge E0.
    task automatic start_op(input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // lat counts falling edges after E0 until done is seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_mult(input string name, input logic [31:0] ia, input logic [31:0] ib,
                           input logic [63:0] exp);
        int lat;
        int bc;
        start_op(ia, ib);
        wait_done(lat, bc);
        check({name, " latency"}, 64'(lat), 64'd32);
        check({name, " busy_cycles"}, 64'(bc), 64'd32);
        check({name, " product"}, p, exp);
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({name, " single_done"}, 64'(done), 64'd0);
        check({name, " p_hold_idle"}, p, exp);
    endtask

    initial begin
        vec_t vecs [7];
        int   lat;
        int   bc;
        int   n_done;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'd3,         32'd5,          64'd15};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
        vecs[2] = '{32'd0,         32'hDEADBEEF,   64'd0};
        vecs[3] = '{32'h80000000,  32'd2,          64'h1_00000000};
        vecs[4] = '{32'hDEADBEEF,  32'd1,          64'hDEADBEEF};
        vecs[5] = '{32'd1,         32'hFFFFFFFF,   64'hFFFFFFFF};
        vecs[6] = '{32'h10000,     32'h10000,      64'h1_00000000};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset_state", {p[61:0], busy, done}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_after_reset", {p[61:0], busy, done}, '0);
        end

        for (int i = 0; i < 7; i++) begin
            do_mult($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vp);
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'hFFFFFFFF;
            if (i == 1) rb = 32'h80000001;
            do_mult($sformatf("rand%0d", i), ra, rb, model(ra, rb));
        end

        // Start pulse while busy must be ignored.
        start_op(32'd7, 32'd9);
        repeat (10) @(negedge clk);
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 11;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("busy_start latency", 64'(lat), 64'd32);
        check("busy_start product", p, 64'd63);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("busy_start no_second_done", 64'(n_done), 64'd0);
        check("busy_start p_hold", p, 64'd63);

        // Back-to-back: new start held during the done cycle.
        start_op(32'd12, 32'd12);
        wait_done(lat, bc);
        check("b2b first product", p, 64'd144);
        a     = 32'd1000;
        b     = 32'd1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b accepted busy", 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b spacing", 64'(lat), 64'd33);
        check("b2b second product", p, 64'd1000000);
        @(negedge clk);

        // Asynchronous reset mid-run.
        start_op(32'h12345678, 32'h12345678);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset busy", 64'(busy), 64'd0);
        check("async_reset done", 64'(done), 64'd0);
        check("async_reset p", p, 64'd0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("async_reset no_done", 64'(n_done), 64'd0);
        do_mult("after_reset", 32'd2, 32'd3, 64'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
